// File: rtl/beam_steer_scheduler.sv
// Per-beam steering-delay controller: holds a delay table, loads one beam onto the
// channel delay lines, waits for them to flush, then gates output valid for a dwell.
module beam_steer_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int NUM_BEAMS = 8,
  parameter int MAX_DELAY = 30,
  parameter int DW        = 5,
  parameter int BW        = 3,
  parameter int CW        = 2,
  parameter int DWELL     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 scan_mode,
  input  logic [BW-1:0]        fixed_beam,
  input  logic                 sample_tick,
  input  logic                 cfg_we,
  input  logic [BW-1:0]        cfg_beam,
  input  logic [CW-1:0]        cfg_ch,
  input  logic [DW-1:0]        cfg_delay,
  output logic [NUM_CH*DW-1:0] ch_delay,
  output logic                 delay_load,
  output logic [BW-1:0]        cur_beam,
  output logic                 out_valid,
  output logic                 beam_done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DWELL
  } state_t;

  // One counter serves both the settle and the dwell phase.
  localparam int              LP_CMAX       = (MAX_DELAY > DWELL - 1) ? MAX_DELAY : DWELL - 1;
  localparam int              TW            = $clog2(LP_CMAX + 1);
  localparam logic [BW-1:0]   LP_LAST_BEAM  = BW'(NUM_BEAMS - 1);
  localparam logic [TW-1:0]   LP_SETTLE_END = TW'(MAX_DELAY);
  localparam logic [TW-1:0]   LP_DWELL_END  = TW'(DWELL - 1);
  localparam logic [DW-1:0]   LP_DELAY_MAX  = DW'(MAX_DELAY);

  logic [NUM_CH-1:0][DW-1:0] r_table [NUM_BEAMS];

  state_t                    r_state;
  logic [TW-1:0]             r_cnt;
  logic [BW-1:0]             r_target;
  logic [BW-1:0]             r_cur_beam;
  logic [NUM_CH-1:0][DW-1:0] r_ch_delay;
  logic                      r_delay_load;
  logic                      r_beam_done;
  logic                      r_dirty;

  logic                      w_wr_ok;
  logic [DW-1:0]             w_wr_data;
  logic [BW-1:0]             w_fixed;
  logic [BW-1:0]             w_next_beam;
  logic                      w_dirty;
  logic                      w_hit_target;

  assign w_wr_ok      = cfg_we && (int'(cfg_beam) < NUM_BEAMS) && (int'(cfg_ch) < NUM_CH);
  assign w_wr_data    = (int'(cfg_delay) > MAX_DELAY) ? LP_DELAY_MAX : cfg_delay;
  assign w_fixed      = (int'(fixed_beam) >= NUM_BEAMS) ? LP_LAST_BEAM : fixed_beam;
  assign w_next_beam  = (r_cur_beam == LP_LAST_BEAM) ? '0 : r_cur_beam + 1'b1;
  // A write landing on the live beam in the same cycle as the dwell end still forces a reload.
  assign w_dirty      = r_dirty | (w_wr_ok && (cfg_beam == r_cur_beam));
  assign w_hit_target = w_wr_ok && (cfg_beam == r_target);

  // NOTE: the table is a plain register array, so clearing it on reset is cheap and
  // guarantees a freshly reset array steers every channel with zero delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BEAMS; b++) begin
        r_table[b] <= '0;
      end
    end else if (w_wr_ok) begin
      r_table[cfg_beam][cfg_ch] <= w_wr_data;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch reads the
  // pre-edge values; the pulse outputs default low and are raised only where needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_target     <= '0;
      r_cur_beam   <= '0;
      r_ch_delay   <= '0;
      r_delay_load <= 1'b0;
      r_beam_done  <= 1'b0;
      r_dirty      <= 1'b0;
    end else begin
      r_delay_load <= 1'b0;
      r_beam_done  <= 1'b0;
      r_dirty      <= w_dirty;

      if (!enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_target <= scan_mode ? '0 : w_fixed;
            r_cnt    <= '0;
            r_state  <= S_LOAD;
          end

          S_LOAD: begin
            r_ch_delay   <= r_table[r_target];
            r_cur_beam   <= r_target;
            r_delay_load <= 1'b1;
            r_dirty      <= w_hit_target;
            r_cnt        <= '0;
            r_state      <= S_SETTLE;
          end

          S_SETTLE: begin
            if (sample_tick) begin
              if (r_cnt == LP_SETTLE_END) begin
                r_cnt   <= '0;
                r_state <= S_DWELL;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end

          S_DWELL: begin
            if (sample_tick) begin
              if (r_cnt == LP_DWELL_END) begin
                r_beam_done <= 1'b1;
                r_cnt       <= '0;
                if (scan_mode) begin
                  r_target <= w_next_beam;
                  r_state  <= S_LOAD;
                end else if ((w_fixed != r_cur_beam) || w_dirty) begin
                  r_target <= w_fixed;
                  r_state  <= S_LOAD;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ch_delay   = r_ch_delay;
  assign delay_load = r_delay_load;
  assign cur_beam   = r_cur_beam;
  assign beam_done  = r_beam_done;
  assign out_valid  = (r_state == S_DWELL);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_beam_steer_scheduler.sv
// Directed bench for beam_steer_scheduler: NUM_BEAMS=4, DWELL=8, sample_tick every 4th
// cycle, plus a NUM_BEAMS=3 instance for the fixed-beam clamp and out-of-range writes.
module tb_beam_steer_scheduler;

  localparam int NUM_CH = 4, MAX_DELAY = 30, DW = 5, BW = 2, CW = 2, DWELL = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable, en3;
  logic                 scan_mode;
  logic [BW-1:0]        fixed_beam;
  logic [BW-1:0]        fixed3;
  logic                 sample_tick;
  logic                 cfg_we, cfg_we3;
  logic [BW-1:0]        cfg_beam;
  logic [CW-1:0]        cfg_ch;
  logic [DW-1:0]        cfg_delay;
  logic [NUM_CH*DW-1:0] ch_delay, ch3;
  logic                 delay_load, load3;
  logic [BW-1:0]        cur_beam, cur3;
  logic                 out_valid, valid3;
  logic                 beam_done, done3;
  logic                 busy, busy3;

  always #5 clk = ~clk;

  beam_steer_scheduler #(
    .NUM_CH(NUM_CH), .NUM_BEAMS(4), .MAX_DELAY(MAX_DELAY), .DW(DW), .BW(BW), .CW(CW), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .scan_mode(scan_mode), .fixed_beam(fixed_beam),
    .sample_tick(sample_tick), .cfg_we(cfg_we), .cfg_beam(cfg_beam), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay), .ch_delay(ch_delay), .delay_load(delay_load), .cur_beam(cur_beam),
    .out_valid(out_valid), .beam_done(beam_done), .busy(busy)
  );

  assign fixed3 = 2'd3;

  beam_steer_scheduler #(
    .NUM_CH(NUM_CH), .NUM_BEAMS(3), .MAX_DELAY(MAX_DELAY), .DW(DW), .BW(BW), .CW(CW), .DWELL(DWELL)
  ) dut3 (
    .clk(clk), .rst(rst), .enable(en3), .scan_mode(1'b0), .fixed_beam(fixed3),
    .sample_tick(sample_tick), .cfg_we(cfg_we3), .cfg_beam(cfg_beam), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay), .ch_delay(ch3), .delay_load(load3), .cur_beam(cur3),
    .out_valid(valid3), .beam_done(done3), .busy(busy3)
  );

  int n_cmp = 0, n_mis = 0;
  int tick_phase = 0;
  int n_load = 0, n_done = 0, n_rise = 0, n_fall = 0;
  int n_bad_rise = 0, n_early = 0, n_bad_dwell = 0;
  int ticks_since_load = 1000, dwell_ticks = 0, last_dwell_ticks = 0;
  logic prev_valid = 1'b0;
  logic [BW-1:0] loads[$];
  int exp_seq[5] = '{0, 1, 2, 3, 0};
  int dn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive the tick for this cycle, then observe just after the edge.
  task automatic cycle();
    logic t;
    t = (tick_phase == 3);
    sample_tick = t;
    @(posedge clk);
    #1;
    tick_phase = (tick_phase + 1) % 4;
    if (delay_load) begin
      n_load++;
      loads.push_back(cur_beam);
      ticks_since_load = 0;
    end else if (t) begin
      ticks_since_load++;
    end
    if (t && prev_valid) dwell_ticks++;
    if (out_valid && !prev_valid) begin
      n_rise++;
      if (ticks_since_load != MAX_DELAY + 1) n_bad_rise++;
      dwell_ticks = 0;
    end
    if (!out_valid && prev_valid) n_fall++;
    if (out_valid && ticks_since_load < MAX_DELAY + 1) n_early++;
    if (beam_done) begin
      n_done++;
      last_dwell_ticks = dwell_ticks;
      if (dwell_ticks != DWELL) n_bad_dwell++;
      dwell_ticks = 0;
    end
    prev_valid = out_valid;
  endtask

  task automatic write(input logic [BW-1:0] b, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic to3);
    cfg_beam  = b;
    cfg_ch    = c;
    cfg_delay = d;
    cfg_we    = !to3;
    cfg_we3   = to3;
    cycle();
    cfg_we    = 1'b0;
    cfg_we3   = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (n_done < target && k < budget) begin
      cycle();
      k++;
    end
    check(tag, n_done, target);
  endtask

  task automatic wait_load(input int target, input int budget, input string tag);
    int k = 0;
    while (n_load < target && k < budget) begin
      cycle();
      k++;
    end
    check(tag, n_load, target);
  endtask

  task automatic wait_rise(input int target, input int budget, input string tag);
    int k = 0;
    while (n_rise < target && k < budget) begin
      cycle();
      k++;
    end
    check(tag, n_rise, target);
  endtask

  task automatic clear_counts();
    n_load = 0; n_done = 0; n_rise = 0; n_fall = 0;
    n_bad_rise = 0; n_early = 0; n_bad_dwell = 0;
    loads.delete();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; en3 = 1'b0; scan_mode = 1'b0; fixed_beam = '0;
    sample_tick = 1'b0; cfg_we = 1'b0; cfg_we3 = 1'b0; cfg_beam = '0; cfg_ch = '0; cfg_delay = '0;

    // Reset state
    repeat (3) cycle();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_load", delay_load, 0);
    check("rst_done", beam_done, 0);
    check("rst_ch_delay", ch_delay, 0);
    check("rst_cur_beam", cur_beam, 0);
    rst = 1'b1;
    cycle();

    // Table write with clamp, then hold on beam 1
    write(2'd1, 2'd2, 5'd17, 1'b0);
    write(2'd1, 2'd0, 5'd31, 1'b0);
    clear_counts();
    scan_mode = 1'b0; fixed_beam = 2'd1; enable = 1'b1;
    cycle();
    check("load_lat_c1", delay_load, 0);
    cycle();
    check("load_lat_c2", delay_load, 1);
    check("hold1_ch_delay", ch_delay, (17 << 10) | 30);
    check("hold1_cur_beam", cur_beam, 1);
    check("hold1_settle_busy", busy, 1);
    cycle();
    check("load_pulse_width", delay_load, 0);
    wait_rise(1, 400, "settle_rise_timeout");
    check("settle_ticks", ticks_since_load, MAX_DELAY + 1);
    check("settle_early_valid", n_early, 0);
    wait_done(1, 200, "dwell_done_timeout");
    check("dwell_ticks", last_dwell_ticks, DWELL);
    check("hold1_load_count", n_load, 1);
    repeat (10) cycle();
    check("hold1_stays_valid", out_valid, 1);

    // Abort mid-DWELL
    enable = 1'b0;
    cycle();
    check("abort_dwell_busy", busy, 0);
    check("abort_dwell_valid", out_valid, 0);
    dn = n_done;
    repeat (40) cycle();
    check("abort_dwell_no_done", n_done, dn);
    check("abort_keep_ch_delay", ch_delay, (17 << 10) | 30);
    check("abort_keep_cur_beam", cur_beam, 1);

    // Scan wrap over five dwells
    clear_counts();
    scan_mode = 1'b1; enable = 1'b1;
    wait_done(5, 2000, "scan_done_timeout");
    check("scan_load_count", n_load, 5);
    check("scan_loads_size", loads.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("scan_beam_%0d", i), loads[i], exp_seq[i]);
    check("scan_rise_count", n_rise, 5);
    check("scan_bad_rise", n_bad_rise, 0);
    check("scan_early_valid", n_early, 0);
    check("scan_bad_dwell", n_bad_dwell, 0);

    // Abort mid-SETTLE (beam 1 has just been loaded)
    repeat (20) cycle();
    check("settle_pre_busy", busy, 1);
    check("settle_pre_valid", out_valid, 0);
    enable = 1'b0;
    cycle();
    check("abort_settle_busy", busy, 0);
    check("abort_settle_cur_beam", cur_beam, 1);
    repeat (5) cycle();
    check("abort_settle_no_done", n_done, 5);

    // Hold beam 2 across three dwells, then rewrite it
    clear_counts();
    scan_mode = 1'b0; fixed_beam = 2'd2; enable = 1'b1;
    wait_done(3, 1500, "hold2_done_timeout");
    check("hold2_single_load", n_load, 1);
    check("hold2_no_fall", n_fall, 0);
    check("hold2_bad_dwell", n_bad_dwell, 0);
    check("hold2_cur_beam", cur_beam, 2);
    check("hold2_valid", out_valid, 1);
    write(2'd2, 2'd1, 5'd5, 1'b0);
    wait_done(4, 100, "dirty_done_timeout");
    wait_load(2, 10, "dirty_reload_timeout");
    check("dirty_ch_delay", ch_delay, 5 << 5);
    check("dirty_cur_beam", cur_beam, 2);
    check("dirty_fall", n_fall, 1);
    wait_rise(2, 400, "dirty_rise_timeout");
    check("dirty_settle_ticks", ticks_since_load, MAX_DELAY + 1);

    // Async reset mid-DWELL
    repeat (6) cycle();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_ch_delay", ch_delay, 0);
    check("arst_cur_beam", cur_beam, 0);
    enable = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    clear_counts();
    fixed_beam = 2'd1; enable = 1'b1;
    wait_load(1, 10, "post_rst_load_timeout");
    check("table_cleared", ch_delay, 0);
    check("post_rst_cur_beam", cur_beam, 1);

    // NUM_BEAMS=3 instance: beam 3 write ignored, fixed_beam 3 clamps to 2
    write(2'd2, 2'd3, 5'd7, 1'b1);
    write(2'd3, 2'd3, 5'd11, 1'b1);
    en3 = 1'b1;
    repeat (3) cycle();
    check("clamp_cur_beam", cur3, 2);
    check("clamp_ch_delay", ch3, 7 << 15);
    check("clamp_busy", busy3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
